// File: rtl/switch_debouncer.sv
// switch_debouncer: per-lane two-flop synchronizer followed by a saturating
// debounce counter. A lane's clean level flips only after the synchronized
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Each flip raises a one-cycle registered pulse on that lane.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   sw         - raw asynchronous switch inputs, WIDTH lanes
//   sw_clean   - debounced, synchronized levels
//   sw_changed - one-cycle pulse per lane when sw_clean toggles
//   any_change - OR of sw_changed (combinational from registers)

// One debounce lane: sync1 -> sync2 -> counter/clean/changed.
module switch_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic clean,
  output logic changed
);
  // Terminal count; reaching it while still disagreeing commits the new level.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      clean   <= 1'b0;
      changed <= 1'b0;
    end else begin
      sync1   <= sw;
      sync2   <= sync1;
      changed <= 1'b0;
      if (sync2 == clean) begin
        // Any agreement discards partial progress.
        cnt <= '0;
      end else if (cnt == LAST) begin
        clean   <= sync2;
        cnt     <= '0;
        changed <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int WIDTH           = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    switch_debouncer_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CW              (CW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .sw      (sw[i]),
      .clean   (sw_clean[i]),
      .changed (sw_changed[i])
    );
  end

  assign any_change = |sw_changed;
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer at DEBOUNCE_CYCLES=4, WIDTH=7, plus a
// second instance at DEBOUNCE_CYCLES=1 for the minimum-latency case.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_switch_debouncer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] sw = '0;
  logic [6:0] sw_clean, sw_changed;
  logic       any_change;
  logic [1:0] sw1 = '0;
  logic [1:0] sw1_clean, sw1_changed;
  logic       any1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  switch_debouncer #(.DEBOUNCE_CYCLES(4), .WIDTH(7)) u_dut (
    .clk(clk), .reset(reset), .sw(sw),
    .sw_clean(sw_clean), .sw_changed(sw_changed), .any_change(any_change)
  );

  switch_debouncer #(.DEBOUNCE_CYCLES(1), .WIDTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .sw(sw1),
    .sw_clean(sw1_clean), .sw_changed(sw1_changed), .any_change(any1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw = '0;
    sw1 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic quiet;
    int   rises, pulses;
    logic [6:0] prev;

    // Reset: 3 cycles, sw wiggling must not matter while reset is high.
    reset = 1'b1;
    sw = 7'h00;
    tick();
    sw = 7'h7F;
    tick();
    sw = 7'h00;
    tick();
    chk("rst_clean", 32'(sw_clean), 32'h00);
    chk("rst_changed", 32'(sw_changed), 32'h00);
    chk("rst_any", 32'(any_change), 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_after_clean", 32'(sw_clean), 32'h00);

    // Single switch: capture edge E0, clean rises at E5.
    sw = 7'h01;
    quiet = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (sw_clean != 7'h00 || sw_changed != 7'h00 || any_change) quiet = 1'b0;
    end
    chk("single_early", 32'(quiet), 32'h1);
    tick();
    chk("single_clean", 32'(sw_clean), 32'h01);
    chk("single_changed", 32'(sw_changed), 32'h01);
    chk("single_any", 32'(any_change), 32'h1);
    tick();
    chk("single_pulse_end", 32'(sw_changed), 32'h00);
    chk("single_any_end", 32'(any_change), 32'h0);
    chk("single_hold", 32'(sw_clean), 32'h01);

    // Glitch: sw[3] high for 3 captures reaches count 3 but never commits.
    do_reset();
    sw = 7'h08;
    tick(); tick(); tick();
    sw = 7'h00;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sw_clean != 7'h00 || sw_changed != 7'h00 || any_change) quiet = 1'b0;
    end
    chk("glitch_quiet", 32'(quiet), 32'h1);
    chk("glitch_clean", 32'(sw_clean), 32'h00);

    // Simultaneous: all lanes rise together, then fall together.
    do_reset();
    sw = 7'h7F;
    for (int i = 0; i <= 4; i++) tick();
    chk("simul_early", 32'(sw_clean), 32'h00);
    tick();
    chk("simul_clean", 32'(sw_clean), 32'h7F);
    chk("simul_changed", 32'(sw_changed), 32'h7F);
    tick();
    chk("simul_pulse_end", 32'(sw_changed), 32'h00);
    sw = 7'h00;
    for (int i = 0; i <= 4; i++) tick();
    chk("fall_early", 32'(sw_clean), 32'h7F);
    tick();
    chk("fall_clean", 32'(sw_clean), 32'h00);
    chk("fall_changed", 32'(sw_changed), 32'h7F);

    // Bounce: sw[5] toggles every 2 cycles for 20 cycles, then holds high.
    do_reset();
    rises = 0;
    pulses = 0;
    prev = sw_clean;
    for (int i = 0; i < 50; i++) begin
      sw = (i >= 20 || ((i / 2) % 2 == 0)) ? 7'h20 : 7'h00;
      tick();
      if (!prev[5] && sw_clean[5]) rises++;
      if (sw_changed[5]) pulses++;
      prev = sw_clean;
    end
    chk("bounce_rises", 32'(rises), 32'd1);
    chk("bounce_pulses", 32'(pulses), 32'd1);
    chk("bounce_clean", 32'(sw_clean), 32'h20);

    // Mid-count reset: counter at 2 when reset pulses; full latency after.
    do_reset();
    sw = 7'h04;
    tick(); tick(); tick(); tick();   // E0..E3, count now 2
    reset = 1'b1;
    tick();
    chk("midrst_clean", 32'(sw_clean), 32'h00);
    chk("midrst_changed", 32'(sw_changed), 32'h00);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (sw_clean != 7'h00 || sw_changed != 7'h00) quiet = 1'b0;
    end
    chk("midrst_early", 32'(quiet), 32'h1);
    tick();
    chk("midrst_clean_up", 32'(sw_clean), 32'h04);
    chk("midrst_pulse", 32'(sw_changed), 32'h04);

    // DEBOUNCE_CYCLES=1: clean follows 2 edges after capture.
    do_reset();
    sw1 = 2'b10;
    tick();
    tick();
    chk("d1_early", 32'(sw1_clean), 32'h0);
    tick();
    chk("d1_clean", 32'(sw1_clean), 32'h2);
    chk("d1_changed", 32'(sw1_changed), 32'h2);
    chk("d1_any", 32'(any1), 32'h1);
    tick();
    chk("d1_pulse_end", 32'(sw1_changed), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
